// File: rtl/mhb_decim_chain_if.sv
// rtl/mhb_decim_chain_if.sv - sample/control bundle for the half-band decimation chain
interface mhb_decim_chain_if #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 20,
    parameter int SEL_W = 3
);
    logic                    clr;
    logic [SEL_W-1:0]        decim_sel;
    logic signed [IN_W-1:0]  din;
    logic                    din_valid;
    logic signed [OUT_W-1:0] dout;
    logic                    dout_valid;
    logic                    ovf;

    modport master (
        output clr, decim_sel, din, din_valid,
        input  dout, dout_valid, ovf
    );

    modport slave (
        input  clr, decim_sel, din, din_valid,
        output dout, dout_valid, ovf
    );
endinterface

// File: rtl/mhb_decim_chain.sv
// rtl/mhb_decim_chain.sv - runtime-selectable cascade of 7-tap half-band decimate-by-2 stages
module mhb_decim_chain #(
    parameter int IN_W   = 8,
    parameter int OUT_W  = 20,
    parameter int STAGES = 6,
    parameter int SEL_W  = 3
) (
    input  logic             clk,
    input  logic             reset,
    mhb_decim_chain_if.slave bus
);
    localparam int ACC_W = OUT_W + 6;
    localparam int SH_W  = OUT_W - IN_W;
    localparam logic [SEL_W-1:0]        SEL_MAX = SEL_W'(STAGES);
    localparam logic signed [ACC_W-1:0] RND     = ACC_W'(16);

    function automatic logic signed [ACC_W-1:0] sx(input logic signed [OUT_W-1:0] v);
        return {{(ACC_W-OUT_W){v[OUT_W-1]}}, v};
    endfunction

    logic [SEL_W-1:0]        sel_c;
    logic [SEL_W-1:0]        sel_q;
    logic                    flush;
    logic                    any_hit;
    logic signed [OUT_W-1:0] s0_data;
    logic                    s0_valid;

    // Index 0 is the registered scaled input, index j is stage j's registered output.
    logic signed [OUT_W-1:0] sd [0:STAGES];
    logic                    sv [0:STAGES];
    logic                    hit [1:STAGES];

    assign sd[0] = s0_data;
    assign sv[0] = s0_valid;

    // Clamp the ratio select, detect a ratio change (acts as a flush) and merge stage saturations.
    always_comb begin
        sel_c   = (bus.decim_sel > SEL_MAX) ? SEL_MAX : bus.decim_sel;
        flush   = bus.clr | (sel_c != sel_q);
        any_hit = 1'b0;
        for (int j = 1; j <= STAGES; j++) begin
            any_hit = any_hit | hit[j];
        end
    end

    // Shadow the ratio select and register the MSB-aligned input sample.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_q    <= '0;
            s0_data  <= '0;
            s0_valid <= 1'b0;
        end else begin
            sel_q <= sel_c;
            if (flush) begin
                s0_data  <= '0;
                s0_valid <= 1'b0;
            end else begin
                s0_valid <= bus.din_valid;
                // Sign-extend then shift left by OUT_W-IN_W reduces to appending zeros.
                if (bus.din_valid) begin
                    s0_data <= {bus.din, {SH_W{1'b0}}};
                end
            end
        end
    end

    for (genvar j = 1; j <= STAGES; j++) begin : g_stage
        // d holds x0..x5 as they stand after the last shift; on a new sample the line
        // becomes {sample, d[0..5]}, so the old x6 is never needed.
        logic signed [OUT_W-1:0] d [0:5];
        logic                    phase;
        logic signed [ACC_W-1:0] acc;
        logic signed [ACC_W-1:0] yw;
        logic                    sat;
        logic signed [OUT_W-1:0] y;
        logic signed [OUT_W-1:0] y_q;
        logic                    v_q;

        // Taps -1,0,9,16,9,0,-1 on the post-shift line, round half up, saturate.
        always_comb begin
            acc = -sx(sd[j-1])
                  + (sx(d[1]) <<< 3) + sx(d[1])
                  + (sx(d[2]) <<< 4)
                  + (sx(d[3]) <<< 3) + sx(d[3])
                  - sx(d[5]);
            yw  = (acc + RND) >>> 5;
            sat = !((&yw[ACC_W-1:OUT_W-1]) || !(|yw[ACC_W-1:OUT_W-1]));
            if (sat) begin
                y = yw[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
            end else begin
                y = yw[OUT_W-1:0];
            end
        end

        assign hit[j] = sv[j-1] & phase & sat;
        assign sd[j]  = y_q;
        assign sv[j]  = v_q;

        // Shift on each input valid; every second sample registers a decimated output.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                d     <= '{default: '0};
                phase <= 1'b0;
                y_q   <= '0;
                v_q   <= 1'b0;
            end else if (flush) begin
                d     <= '{default: '0};
                phase <= 1'b0;
                y_q   <= '0;
                v_q   <= 1'b0;
            end else begin
                v_q <= 1'b0;
                if (sv[j-1]) begin
                    d[0] <= sd[j-1];
                    for (int i = 1; i < 6; i++) begin
                        d[i] <= d[i-1];
                    end
                    phase <= ~phase;
                    if (phase) begin
                        y_q <= y;
                        v_q <= 1'b1;
                    end
                end
            end
        end
    end

    // Register the selected source; dout holds between strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.dout       <= '0;
            bus.dout_valid <= 1'b0;
        end else if (flush) begin
            bus.dout       <= '0;
            bus.dout_valid <= 1'b0;
        end else begin
            bus.dout_valid <= sv[sel_q];
            if (sv[sel_q]) begin
                bus.dout <= sd[sel_q];
            end
        end
    end

    // Sticky overflow: only an explicit clr clears it, a ratio change does not.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.ovf <= 1'b0;
        end else if (bus.clr) begin
            bus.ovf <= 1'b0;
        end else if (any_hit && !flush) begin
            bus.ovf <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mhb_decim_chain.sv
// tb/tb_mhb_decim_chain.sv - directed-vector bench for mhb_decim_chain
module tb_mhb_decim_chain;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   vectors = 0;
    int   errors  = 0;
    int   got[$];

    always #5 clk = ~clk;

    mhb_decim_chain_if #(.IN_W(8), .OUT_W(20), .SEL_W(3)) bus ();

    mhb_decim_chain #(
        .IN_W(8), .OUT_W(20), .STAGES(6), .SEL_W(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.dout_valid) got.push_back(int'(bus.dout));
    endtask

    task automatic feed(input logic v, input logic signed [7:0] dval, input int n);
        bus.din_valid = v;
        bus.din       = dval;
        repeat (n) tick();
        bus.din_valid = 1'b0;
    endtask

    task automatic restart(input logic [2:0] k);
        bus.decim_sel = k;
        bus.din_valid = 1'b0;
        bus.clr       = 1'b1;
        tick();
        bus.clr = 1'b0;
        tick();
        got.delete();
    endtask

    task automatic test_reset();
        vectors++;
        if (bus.dout !== 20'sd0) begin errors++; $display("FAIL reset_dout: got %0d expected 0", bus.dout); end
        vectors++;
        if (bus.dout_valid !== 1'b0) begin errors++; $display("FAIL reset_dout_valid: got %0b expected 0", bus.dout_valid); end
        vectors++;
        if (bus.ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %0b expected 0", bus.ovf); end
        reset = 1'b0;
        tick();
        vectors++;
        if (bus.dout_valid !== 1'b0) begin errors++; $display("FAIL reset_idle_valid: got %0b expected 0", bus.dout_valid); end
    endtask

    task automatic run_dc(input string tag);
        int exp_v[8] = '{-8192, 196608, 270336, 262144, 262144, 262144, 262144, 262144};
        restart(3'd1);
        feed(1'b1, 8'sd64, 16);
        feed(1'b0, 8'sd0, 6);
        vectors++;
        if (got.size() != 8) begin errors++; $display("FAIL %s_count: got %0d expected 8", tag, got.size()); end
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (i >= got.size() || got[i] !== exp_v[i]) begin
                errors++;
                $display("FAIL %s_out%0d: got %0d expected %0d", tag, i, (i < got.size()) ? got[i] : 0, exp_v[i]);
            end
        end
        vectors++;
        if (bus.ovf !== 1'b0) begin errors++; $display("FAIL %s_ovf: got %0b expected 0", tag, bus.ovf); end
    endtask

    task automatic test_dc();
        run_dc("dc");
    endtask

    task automatic test_bypass();
        restart(3'd0);
        for (int n = 1; n <= 3; n++) begin
            feed(1'b1, 8'(n), 1);
            vectors++;
            if (bus.dout_valid !== 1'b0) begin errors++; $display("FAIL bypass_early%0d: got %0b expected 0", n, bus.dout_valid); end
            tick();
            vectors++;
            if (bus.dout_valid !== 1'b1 || bus.dout !== 20'(n * 4096)) begin
                errors++;
                $display("FAIL bypass_out%0d: got valid=%0b dout=%0d expected valid=1 dout=%0d", n, bus.dout_valid, bus.dout, n * 4096);
            end
            tick();
            vectors++;
            if (bus.dout_valid !== 1'b0 || bus.dout !== 20'(n * 4096)) begin
                errors++;
                $display("FAIL bypass_hold%0d: got valid=%0b dout=%0d expected valid=0 dout=%0d", n, bus.dout_valid, bus.dout, n * 4096);
            end
        end
    endtask

    task automatic test_full_chain();
        restart(3'd6);
        feed(1'b1, 8'sd64, 1280);
        feed(1'b0, 8'sd0, 20);
        vectors++;
        if (got.size() != 20) begin errors++; $display("FAIL full_count: got %0d expected 20", got.size()); end
        for (int i = 18; i < 20; i++) begin
            vectors++;
            if (i >= got.size() || got[i] !== 262144) begin
                errors++;
                $display("FAIL full_out%0d: got %0d expected 262144", i, (i < got.size()) ? got[i] : 0);
            end
        end
    endtask

    task automatic test_saturation();
        int exp_v[4] = '{-16256, 390144, 524287, 520192};
        restart(3'd1);
        feed(1'b1, 8'sd127, 8);
        feed(1'b0, 8'sd0, 4);
        vectors++;
        if (got.size() != 4) begin errors++; $display("FAIL sat_count: got %0d expected 4", got.size()); end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (i >= got.size() || got[i] !== exp_v[i]) begin
                errors++;
                $display("FAIL sat_out%0d: got %0d expected %0d", i, (i < got.size()) ? got[i] : 0, exp_v[i]);
            end
        end
        vectors++;
        if (bus.ovf !== 1'b1) begin errors++; $display("FAIL sat_ovf_set: got %0b expected 1", bus.ovf); end
        feed(1'b0, 8'sd0, 3);
        vectors++;
        if (bus.ovf !== 1'b1) begin errors++; $display("FAIL sat_ovf_sticky: got %0b expected 1", bus.ovf); end
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
        vectors++;
        if (bus.ovf !== 1'b0 || bus.dout !== 20'sd0) begin
            errors++;
            $display("FAIL sat_clr: got ovf=%0b dout=%0d expected ovf=0 dout=0", bus.ovf, bus.dout);
        end
    endtask

    task automatic test_ratio_change();
        int exp_v[3] = '{-6144, 43008, 256000};
        restart(3'd2);
        feed(1'b1, 8'sd64, 12);
        feed(1'b0, 8'sd0, 5);
        vectors++;
        if (got.size() != 3) begin errors++; $display("FAIL rc_k2_count: got %0d expected 3", got.size()); end
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (i >= got.size() || got[i] !== exp_v[i]) begin
                errors++;
                $display("FAIL rc_k2_out%0d: got %0d expected %0d", i, (i < got.size()) ? got[i] : 0, exp_v[i]);
            end
        end
        got.delete();
        bus.decim_sel = 3'd3;
        feed(1'b1, 8'sd64, 1);
        vectors++;
        if (bus.dout_valid !== 1'b0 || bus.dout !== 20'sd0) begin
            errors++;
            $display("FAIL rc_flush: got valid=%0b dout=%0d expected valid=0 dout=0", bus.dout_valid, bus.dout);
        end
        feed(1'b1, 8'sd64, 8);
        feed(1'b0, 8'sd0, 3);
        vectors++;
        if (got.size() != 0) begin errors++; $display("FAIL rc_early: got %0d outputs expected 0", got.size()); end
        tick();
        vectors++;
        if (got.size() != 1 || got[0] !== -1344) begin
            errors++;
            $display("FAIL rc_k3_first: got count=%0d value=%0d expected count=1 value=-1344", got.size(), (got.size() > 0) ? got[0] : 0);
        end
    endtask

    task automatic test_async_reset();
        restart(3'd1);
        feed(1'b1, 8'sd127, 8);
        bus.din_valid = 1'b1;
        vectors++;
        if (bus.ovf !== 1'b1) begin errors++; $display("FAIL areset_pre_ovf: got %0b expected 1", bus.ovf); end
        #2;
        reset = 1'b1;
        #1;
        vectors++;
        if (bus.dout !== 20'sd0 || bus.dout_valid !== 1'b0 || bus.ovf !== 1'b0) begin
            errors++;
            $display("FAIL areset_clear: got dout=%0d valid=%0b ovf=%0b expected 0 0 0", bus.dout, bus.dout_valid, bus.ovf);
        end
        bus.din_valid = 1'b0;
        @(posedge clk);
        #4;
        reset = 1'b0;
        run_dc("post_reset");
    endtask

    initial begin
        bus.clr       = 1'b0;
        bus.decim_sel = 3'd0;
        bus.din       = 8'sd0;
        bus.din_valid = 1'b0;
        #23;
        test_reset();
        test_dc();
        test_bypass();
        test_full_chain();
        test_saturation();
        test_ratio_change();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
